// File: rtl/refresh_pkg.sv
// Shared state encoding and default timing for the DRAM refresh responder.
package refresh_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_CSU,
    ST_RAS,
    ST_PRE
  } state_t;

  localparam int DEF_NBANK     = 2;
  localparam int DEF_TCSR      = 1;
  localparam int DEF_TRAS      = 3;
  localparam int DEF_TRP       = 2;
  localparam int DEF_MAX_BURST = 4;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/refresh_timer.sv
// Phase down-counter shared by CSU/RAS/PRE; loads and decrements only on ce.
module refresh_timer #(
  parameter int W = 3
) (
  input  logic         sys_clk,
  input  logic         resetl,
  input  logic         i_ce,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_done
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge sys_clk) begin
    if (!resetl) begin
      r_cnt <= '0;
    end else if (i_ce) begin
      if (i_load)                     r_cnt <= i_load_val;
      else if (i_dec && r_cnt != '0)  r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/dram_refresh_responder.sv
// CBR refresh engine: wins the memory bus, runs CAS-before-RAS, acks each refresh.
// Define REFRESH_BURST_EN to allow back-to-back refreshes under one bus tenure.
module dram_refresh_responder
  import refresh_pkg::*;
#(
  parameter int NBANK     = DEF_NBANK,
  parameter int TCSR      = DEF_TCSR,
  parameter int TRAS      = DEF_TRAS,
  parameter int TRP       = DEF_TRP,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic             sys_clk,
  input  logic             resetl,
  input  logic             ce,
  input  logic             refreq,
  input  logic             dram_en,
  input  logic             bus_gnt,
  output logic             bus_req,
  output logic [NBANK-1:0] rasl,
  output logic             casl,
  output logic             ack,
  output logic             refbusy
);

  localparam int TW = $clog2(max4(TCSR, TRAS, TRP, MAX_BURST)) + 1;

  state_t           r_state, w_state;
  logic             r_guard, w_guard;
  logic             r_bus_req, w_bus_req;
  logic [NBANK-1:0] r_rasl, w_rasl;
  logic             r_casl, w_casl;
  logic             r_ack, w_ack;
  logic             w_tmr_load, w_tmr_dec, w_tmr_done;
  logic [TW-1:0]    w_tmr_val;
`ifdef REFRESH_BURST_EN
  logic [TW-1:0]    r_burst_cnt, w_burst_cnt;
`endif

  refresh_timer #(.W(TW)) u_timer (
    .sys_clk    (sys_clk),
    .resetl     (resetl),
    .i_ce       (ce),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_dec      (w_tmr_dec),
    .o_done     (w_tmr_done)
  );

  always_ff @(posedge sys_clk) begin
    if (!resetl) begin
      r_state   <= ST_IDLE;
      r_guard   <= 1'b0;
      r_bus_req <= 1'b0;
      r_rasl    <= '1;
      r_casl    <= 1'b1;
      r_ack     <= 1'b0;
`ifdef REFRESH_BURST_EN
      r_burst_cnt <= '0;
`endif
    end else begin
      r_state   <= w_state;
      r_guard   <= w_guard;
      r_bus_req <= w_bus_req;
      r_rasl    <= w_rasl;
      r_casl    <= w_casl;
      r_ack     <= w_ack;
`ifdef REFRESH_BURST_EN
      r_burst_cnt <= w_burst_cnt;
`endif
    end
  end

  // ack defaults low every sys_clk so it is exactly one sys_clk wide.
  always_comb begin
    w_state    = r_state;
    w_guard    = r_guard;
    w_bus_req  = r_bus_req;
    w_rasl     = r_rasl;
    w_casl     = r_casl;
    w_ack      = 1'b0;
    w_tmr_load = 1'b0;
    w_tmr_dec  = 1'b0;
    w_tmr_val  = '0;
`ifdef REFRESH_BURST_EN
    w_burst_cnt = r_burst_cnt;
`endif
    if (ce) begin
      case (r_state)
        ST_IDLE: begin
`ifdef REFRESH_BURST_EN
          w_burst_cnt = '0;
`endif
          if (r_guard) begin
            w_guard = 1'b0;
          end else if (refreq && dram_en) begin
            w_state   = ST_REQ;
            w_bus_req = 1'b1;
          end
        end
        ST_REQ: begin
          if (!refreq || !dram_en) begin
            w_state   = ST_IDLE;
            w_bus_req = 1'b0;
          end else if (bus_gnt) begin
            w_state    = ST_CSU;
            w_casl     = 1'b0;
            w_tmr_load = 1'b1;
            w_tmr_val  = TW'(TCSR - 1);
          end
        end
        ST_CSU: begin
          if (w_tmr_done) begin
            w_state    = ST_RAS;
            w_rasl     = '0;
            w_tmr_load = 1'b1;
            w_tmr_val  = TW'(TRAS - 1);
          end else begin
            w_tmr_dec = 1'b1;
          end
        end
        ST_RAS: begin
          if (w_tmr_done) begin
            w_state    = ST_PRE;
            w_rasl     = '1;
            w_casl     = 1'b1;
            w_tmr_load = 1'b1;
            w_tmr_val  = TW'(TRP - 1);
          end else begin
            w_tmr_dec = 1'b1;
          end
        end
        ST_PRE: begin
`ifdef REFRESH_BURST_EN
          // guard high in PRE marks the extra ce spent re-sampling refreq after ack
          if (r_guard) begin
            w_guard = 1'b0;
            if (refreq && dram_en) begin
              w_state     = ST_CSU;
              w_casl      = 1'b0;
              w_tmr_load  = 1'b1;
              w_tmr_val   = TW'(TCSR - 1);
              w_burst_cnt = r_burst_cnt + 1'b1;
            end else begin
              w_state   = ST_IDLE;
              w_bus_req = 1'b0;
            end
          end else if (w_tmr_done) begin
            w_ack   = 1'b1;
            w_guard = 1'b1;
            if (!(refreq && dram_en && r_burst_cnt < TW'(MAX_BURST - 1))) begin
              w_state   = ST_IDLE;
              w_bus_req = 1'b0;
            end
          end else begin
            w_tmr_dec = 1'b1;
          end
`else
          if (w_tmr_done) begin
            w_ack     = 1'b1;
            w_guard   = 1'b1;
            w_state   = ST_IDLE;
            w_bus_req = 1'b0;
          end else begin
            w_tmr_dec = 1'b1;
          end
`endif
        end
        default: begin
          w_state   = ST_IDLE;
          w_bus_req = 1'b0;
          w_rasl    = '1;
          w_casl    = 1'b1;
        end
      endcase
    end
  end

  assign bus_req = r_bus_req;
  assign rasl    = r_rasl;
  assign casl    = r_casl;
  assign ack     = r_ack;
  assign refbusy = (r_state != ST_IDLE);

endmodule

// File: tb/tb_dram_refresh_responder.sv
// Directed bench for dram_refresh_responder; each memory clock is a ce sys_clk then an idle sys_clk.
module tb_dram_refresh_responder;

  logic       sys_clk = 1'b0;
  logic       resetl, ce, refreq, dram_en, bus_gnt;
  logic       bus_req, casl, ack, refbusy;
  logic [1:0] rasl;

  int n_vec  = 0;
  int n_fail = 0;
  int ack_cnt = 0;

  dram_refresh_responder dut (
    .sys_clk (sys_clk),
    .resetl  (resetl),
    .ce      (ce),
    .refreq  (refreq),
    .dram_en (dram_en),
    .bus_gnt (bus_gnt),
    .bus_req (bus_req),
    .rasl    (rasl),
    .casl    (casl),
    .ack     (ack),
    .refbusy (refbusy)
  );

  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk) if (ack) ack_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one ce edge, sample 1ns after; then one idle sys_clk so ack has dropped
  task automatic mclk();
    ce = 1'b1;
    @(posedge sys_clk); #1;
    ce = 1'b0;
  endtask

  task automatic gap();
    @(posedge sys_clk); #1;
  endtask

  task automatic strobes(input string tag, input logic [1:0] r, input logic c, input logic b);
    chk({tag, ".rasl"}, 32'(rasl), 32'(r));
    chk({tag, ".casl"}, 32'(casl), 32'(c));
    chk({tag, ".bus_req"}, 32'(bus_req), 32'(b));
  endtask

  initial begin
    int a0;
    resetl = 1'b0; ce = 1'b0; refreq = 1'b0; dram_en = 1'b0; bus_gnt = 1'b0;
    repeat (3) gap();
    strobes("reset", 2'b11, 1'b1, 1'b0);
    chk("reset.ack", 32'(ack), 32'd0);
    chk("reset.refbusy", 32'(refbusy), 32'd0);

    // basic refresh, grant two ce after request
    resetl = 1'b1; dram_en = 1'b1; refreq = 1'b1;
    mclk(); gap();
    strobes("req", 2'b11, 1'b1, 1'b1);
    chk("req.refbusy", 32'(refbusy), 32'd1);
    mclk(); gap();
    strobes("req_wait", 2'b11, 1'b1, 1'b1);
    bus_gnt = 1'b1;
    mclk(); gap();
    strobes("csu", 2'b11, 1'b0, 1'b1);
    mclk(); gap();
    strobes("ras1", 2'b00, 1'b0, 1'b1);
    mclk(); gap(); mclk(); gap();
    strobes("ras3", 2'b00, 1'b0, 1'b1);
    mclk(); gap();
    strobes("pre1", 2'b11, 1'b1, 1'b1);
    chk("pre1.ack", 32'(ack), 32'd0);
    mclk(); gap();
    chk("pre2.ack", 32'(ack), 32'd0);
    chk("pre2.refbusy", 32'(refbusy), 32'd1);
    mclk();
    chk("done.ack", 32'(ack), 32'd1);
    chk("done.bus_req", 32'(bus_req), 32'd0);
    chk("done.refbusy", 32'(refbusy), 32'd0);
    gap();
    chk("done.ack_width", 32'(ack), 32'd0);
    chk("done.ack_cnt", 32'(ack_cnt), 32'd1);

    // stale refreq for one ce after ack, then dropped
    mclk(); gap();
    chk("stale.bus_req", 32'(bus_req), 32'd0);
    refreq = 1'b0;
    mclk(); gap(); mclk(); gap();
    chk("stale2.bus_req", 32'(bus_req), 32'd0);
    chk("stale2.refbusy", 32'(refbusy), 32'd0);

    // second refresh, refreq held continuously: restart on second ce after ack
    refreq = 1'b1;
    repeat (8) begin mclk(); gap(); end
    chk("r2.ack_cnt", 32'(ack_cnt), 32'd2);
    chk("r2.idle", 32'(refbusy), 32'd0);
    bus_gnt = 1'b0;
    mclk(); gap();
    chk("r2.guard", 32'(bus_req), 32'd0);
    mclk(); gap();
    chk("r2.rereq", 32'(bus_req), 32'd1);

    // request withdrawn in REQ with no grant
    refreq = 1'b0;
    mclk(); gap();
    strobes("withdraw", 2'b11, 1'b1, 1'b0);
    chk("withdraw.refbusy", 32'(refbusy), 32'd0);
    chk("withdraw.ack_cnt", 32'(ack_cnt), 32'd2);

    // reset during RAS with ce low
    refreq = 1'b1; bus_gnt = 1'b1;
    repeat (3) begin mclk(); gap(); end
    strobes("pre_rst", 2'b00, 1'b0, 1'b1);
    resetl = 1'b0;
    gap();
    strobes("midrst", 2'b11, 1'b1, 1'b0);
    chk("midrst.refbusy", 32'(refbusy), 32'd0);
    chk("midrst.ack", 32'(ack), 32'd0);
    resetl = 1'b1;

    // disabled DRAM stays idle
    dram_en = 1'b0;
    repeat (3) begin mclk(); gap(); end
    chk("dis.refbusy", 32'(refbusy), 32'd0);
    chk("dis.bus_req", 32'(bus_req), 32'd0);

    // ce frozen mid-RAS, dram_en dropped during RAS: refresh still completes
    dram_en = 1'b1;
    repeat (3) begin mclk(); gap(); end
    a0 = ack_cnt;
    dram_en = 1'b0;
    repeat (10) gap();
    strobes("frz", 2'b00, 1'b0, 1'b1);
    mclk(); gap(); mclk(); gap();
    strobes("frz.ras3", 2'b00, 1'b0, 1'b1);
    mclk(); gap();
    strobes("frz.pre", 2'b11, 1'b1, 1'b1);
    mclk(); gap(); mclk(); gap();
    chk("frz.ack_cnt", 32'(ack_cnt - a0), 32'd1);
    chk("frz.idle", 32'(refbusy), 32'd0);

`ifdef REFRESH_BURST_EN
    // six refreshes with refreq held: four under one tenure, release, then two more
    begin
      int drops;
      int acks_at_drop;
      logic prev;
      mclk(); gap(); mclk(); gap();
      dram_en = 1'b1; refreq = 1'b1; bus_gnt = 1'b1;
      a0 = ack_cnt; drops = 0; acks_at_drop = -1; prev = bus_req;
      for (int i = 0; i < 200 && (ack_cnt - a0) < 6; i++) begin
        mclk();
        if (prev && !bus_req) begin
          drops++;
          if (acks_at_drop < 0) acks_at_drop = ack_cnt - a0 + (ack ? 0 : 0);
        end
        prev = bus_req;
        gap();
      end
      refreq = 1'b0;
      mclk(); gap(); mclk(); gap();
      chk("burst.first_tenure", 32'(acks_at_drop), 32'd4);
      chk("burst.total", 32'(ack_cnt - a0), 32'd6);
      chk("burst.released", 32'(bus_req), 32'd0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
